// File: rtl/mult_div_ctrl_if.sv
// Handshake and control bundle between the main control unit and the
// multiply/divide sequencer.
interface mult_div_ctrl_if;
   logic       start;
   logic       op;
   logic       divisor_zero;
   logic       abort;
   logic       busy;
   logic       load;
   logic       mult_step;
   logic       div_step;
   logic       hi_write;
   logic       lo_write;
   logic       hilo_src;
   logic       done;
   logic       div_by_zero;
   logic [5:0] count;

   modport master (
      output start, op, divisor_zero, abort,
      input  busy, load, mult_step, div_step, hi_write, lo_write,
             hilo_src, done, div_by_zero, count
   );

   modport slave (
      input  start, op, divisor_zero, abort,
      output busy, load, mult_step, div_step, hi_write, lo_write,
             hilo_src, done, div_by_zero, count
   );
endinterface

// File: rtl/mult_div_ctrl.sv
// Moore sequencer for an iterative multiply/divide datapath: load, ITERATIONS
// step cycles, HI/LO write-back and completion, with divide-by-zero and abort.
module mult_div_ctrl #(
   parameter int ITERATIONS = 32
) (
   input  logic          clock,
   input  logic          reset,
   mult_div_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RUN     = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4,
      S_DIVZERO = 3'd5
   } state_t;

   localparam logic [5:0] CNT_INIT = 6'(ITERATIONS - 1);

   state_t     state_q, state_d;
   logic       op_q, op_d;
   logic [5:0] count_q, count_d;

   // State, captured opcode and iteration counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         count_q <= 6'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
      end
   end

   // Next state; abort outranks every transition except the idle-time start.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = 6'd0;
      if ((state_q != S_IDLE) && bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d = S_LOAD;
                  op_d    = bus.op;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD: begin
               if (op_q && bus.divisor_zero) begin
                  state_d = S_DIVZERO;
               end else begin
                  state_d = S_RUN;
                  count_d = CNT_INIT;
               end
            end
            S_RUN: begin
               if (count_q == 6'd0) begin
                  state_d = S_WRITE;
               end else begin
                  count_d = count_q - 6'd1;
               end
            end
            S_WRITE:   state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            S_DIVZERO: state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Output decode from registered state only.
   always_comb begin
      bus.busy        = (state_q != S_IDLE);
      bus.load        = 1'b0;
      bus.mult_step   = 1'b0;
      bus.div_step    = 1'b0;
      bus.hi_write    = 1'b0;
      bus.lo_write    = 1'b0;
      bus.hilo_src    = 1'b0;
      bus.done        = 1'b0;
      bus.div_by_zero = 1'b0;
      bus.count       = count_q;
      case (state_q)
         S_LOAD: bus.load = 1'b1;
         S_RUN: begin
            bus.mult_step = ~op_q;
            bus.div_step  = op_q;
         end
         S_WRITE: begin
            bus.hi_write = 1'b1;
            bus.lo_write = 1'b1;
            bus.hilo_src = op_q;
         end
         S_DONE: bus.done = 1'b1;
         S_DIVZERO: begin
            bus.done        = 1'b1;
            bus.div_by_zero = 1'b1;
         end
         default: bus.busy = (state_q != S_IDLE);
      endcase
   end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: timeline reference model (cycle index since accept)
// compared against every output each cycle.
module tb_mult_div_ctrl;
   localparam int N = 32;

   logic clock;
   logic reset;
   int   total;
   int   bad;
   int   cyc;

   mult_div_ctrl_if bus ();

   mult_div_ctrl #(.ITERATIONS(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: active operation, cycle index k (LOAD is k=1), opcode, div-by-zero.
   logic m_act;
   int   m_k;
   logic m_op;
   logic m_dz;

   task automatic model_update(input logic s, input logic o, input logic a,
                               input logic d, input logic r);
      if (r) begin
         m_act = 1'b0;
      end else if (m_act && a) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (s) begin
            m_act = 1'b1;
            m_k   = 1;
            m_op  = o;
            m_dz  = 1'b0;
         end
      end else begin
         if (m_k == 1) m_dz = m_op & d;
         m_k++;
         if ((m_dz && m_k == 3) || (!m_dz && m_k == N + 4)) m_act = 1'b0;
      end
   endtask

   // {busy,load,mult,div,hi,lo,src,done,dbz,count[5:0]}
   function automatic logic [14:0] expected_vec();
      logic [8:0] f;
      logic [5:0] c;
      f = 9'd0;
      c = 6'd0;
      if (m_act) begin
         f[8] = 1'b1;
         if (m_k == 1) begin
            f[7] = 1'b1;
         end else if (m_dz) begin
            if (m_k == 2) begin
               f[1] = 1'b1;
               f[0] = 1'b1;
            end
         end else if (m_k <= N + 1) begin
            f[6] = ~m_op;
            f[5] = m_op;
            c    = 6'(N + 1 - m_k);
         end else if (m_k == N + 2) begin
            f[4] = 1'b1;
            f[3] = 1'b1;
            f[2] = m_op;
         end else if (m_k == N + 3) begin
            f[1] = 1'b1;
         end
      end
      return {f, c};
   endfunction

   function automatic logic [14:0] observed_vec();
      return {bus.busy, bus.load, bus.mult_step, bus.div_step, bus.hi_write,
              bus.lo_write, bus.hilo_src, bus.done, bus.div_by_zero, bus.count};
   endfunction

   task automatic tick(input string tag);
      logic s, o, a, d, r;
      logic [14:0] obs, exp_v;
      s = bus.start; o = bus.op; a = bus.abort; d = bus.divisor_zero; r = reset;
      @(posedge clock);
      #1;
      cyc++;
      model_update(s, o, a, d, r);
      obs   = observed_vec();
      exp_v = expected_vec();
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
   endtask

   // Ticks with random start/op noise while an operation is in flight.
   task automatic run_noisy(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if (m_act) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.op    = 1'($urandom_range(0, 1));
         end else begin
            bus.start = 1'b0;
         end
         tick(tag);
      end
      bus.start = 1'b0;
   endtask

   task automatic run_until_k(input int k, input string tag);
      int budget;
      budget = 200;
      while (!(m_act && m_k == k) && budget > 0) begin
         tick(tag);
         budget--;
      end
      total++;
      assert (budget > 0) else begin
         bad++;
         $error("FAIL %s_timeout observed=%0d expected=%0d", tag, m_k, k);
      end
   endtask

   task automatic accept(input logic o, input logic d, input string tag);
      bus.start        = 1'b1;
      bus.op           = o;
      bus.divisor_zero = d;
      tick(tag);
      bus.start = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      m_act = 1'b0; m_k = 0; m_op = 1'b0; m_dz = 1'b0;
      bus.start = 1'b0; bus.op = 1'b0; bus.divisor_zero = 1'b0; bus.abort = 1'b0;
      reset = 1'b1;
      tick("reset");
      tick("reset");
      reset = 1'b0;

      // abort in IDLE is ignored
      bus.abort = 1'b1;
      tick("idle_abort");
      // start together with abort in IDLE is accepted
      accept(1'b0, 1'b0, "mult_accept");
      bus.abort = 1'b0;
      run_noisy(N + 4, "mult");

      accept(1'b1, 1'b0, "div_accept");
      run_noisy(N + 4, "div");

      accept(1'b1, 1'b1, "divzero_accept");
      run_noisy(4, "divzero");

      // divisor_zero is don't-care for MULT
      accept(1'b0, 1'b1, "mult_dz_accept");
      bus.divisor_zero = 1'b0;
      run_noisy(N + 4, "mult_dz");

      // abort when count == 10, then a fresh start right after
      accept(1'b0, 1'b0, "abort_accept");
      run_until_k(N + 1 - 10, "abort_run");
      bus.abort = 1'b1;
      tick("abort_edge");
      bus.abort = 1'b0;
      accept(1'b1, 1'b0, "after_abort_accept");
      run_noisy(N + 4, "after_abort");

      // reset in cycle 20 of a MULT
      accept(1'b0, 1'b0, "rst_accept");
      run_until_k(20, "rst_run");
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick("mid_reset");
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick("post_reset");

      // fully random traffic
      for (int i = 0; i < 1500; i++) begin
         bus.start        = ($urandom_range(0, 3) == 0);
         bus.op           = 1'($urandom_range(0, 1));
         bus.divisor_zero = ($urandom_range(0, 3) == 0);
         bus.abort        = ($urandom_range(0, 59) == 0);
         reset            = ($urandom_range(0, 199) == 0);
         tick("random");
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
